pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use / RAW stall, taken-branch flush,
// operand forwarding selects and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int NUM_SRC  = 3,
  parameter int FWD_EN   = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_use,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      ex_branch_taken,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      if_id_flush,
  output logic                      id_ex_bubble,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  logic                      r_idex_valid;
  logic [REG_AW-1:0]         r_idex_rd;
  logic                      r_idex_regwrite;
  logic                      r_idex_memread;
  logic [NUM_SRC*REG_AW-1:0] r_idex_rs;
  logic [NUM_SRC-1:0]        r_idex_use;

  logic                      r_exmem_valid;
  logic [REG_AW-1:0]         r_exmem_rd;
  logic                      r_exmem_regwrite;

  logic                      r_memwb_valid;
  logic [REG_AW-1:0]         r_memwb_rd;
  logic                      r_memwb_regwrite;

  logic [CNT_W-1:0]          r_stall_cnt;
  logic [CNT_W-1:0]          r_flush_cnt;

  logic [NUM_SRC-1:0]        w_id_m_idex;
  logic [NUM_SRC-1:0]        w_id_m_exmem;
  logic [NUM_SRC-1:0]        w_ex_m_exmem;
  logic [NUM_SRC-1:0]        w_ex_m_memwb;
  logic                      w_hazard;
  logic                      w_stall;
  logic                      w_flush;
  logic                      w_bubble;

  function automatic logic f_match(
    input logic              use_b,
    input logic [REG_AW-1:0] src,
    input logic              stg_valid,
    input logic              stg_regwrite,
    input logic [REG_AW-1:0] stg_rd
  );
    f_match = use_b && stg_valid && stg_regwrite && (src == stg_rd)
              && !((ZERO_REG != 0) && (src == '0));
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] w_id_src;
      logic [REG_AW-1:0] w_ex_src;
      assign w_id_src = id_rs[gi*REG_AW +: REG_AW];
      assign w_ex_src = r_idex_rs[gi*REG_AW +: REG_AW];

      assign w_id_m_idex[gi]  = f_match(id_use[gi], w_id_src, r_idex_valid,
                                        r_idex_regwrite, r_idex_rd);
      assign w_id_m_exmem[gi] = f_match(id_use[gi], w_id_src, r_exmem_valid,
                                        r_exmem_regwrite, r_exmem_rd);
      assign w_ex_m_exmem[gi] = f_match(r_idex_use[gi], w_ex_src, r_exmem_valid,
                                        r_exmem_regwrite, r_exmem_rd);
      assign w_ex_m_memwb[gi] = f_match(r_idex_use[gi], w_ex_src, r_memwb_valid,
                                        r_memwb_regwrite, r_memwb_rd);

      // The youngest producer (EX/MEM) wins over the older one in MEM/WB
      assign fwd_sel[2*gi +: 2] = (FWD_EN == 0) ? 2'd0 :
                                  w_ex_m_exmem[gi] ? 2'd1 :
                                  w_ex_m_memwb[gi] ? 2'd2 : 2'd0;
    end
  endgenerate

  // MEM/WB is never a stall source: the register file writes before it reads
  always_comb begin
    w_hazard = 1'b0;
    if (id_valid) begin
      if (FWD_EN != 0)
        w_hazard = r_idex_memread && (|w_id_m_idex);
      else
        w_hazard = (|w_id_m_idex) || (|w_id_m_exmem);
    end
  end

  // Gating with rst keeps every control output at its idle value while reset is held
  assign w_flush  = rst && ex_branch_taken;
  assign w_stall  = rst && w_hazard && !ex_branch_taken;
  assign w_bubble = w_stall || w_flush;

  assign pc_en        = !w_stall;
  assign if_id_en     = !w_stall;
  assign if_id_flush  = w_flush;
  assign id_ex_bubble = w_bubble;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idex_valid     <= 1'b0;
      r_idex_rd        <= '0;
      r_idex_regwrite  <= 1'b0;
      r_idex_memread   <= 1'b0;
      r_idex_rs        <= '0;
      r_idex_use       <= '0;
      r_exmem_valid    <= 1'b0;
      r_exmem_rd       <= '0;
      r_exmem_regwrite <= 1'b0;
      r_memwb_valid    <= 1'b0;
      r_memwb_rd       <= '0;
      r_memwb_regwrite <= 1'b0;
      r_stall_cnt      <= '0;
      r_flush_cnt      <= '0;
    end else begin
      r_idex_valid     <= id_valid && !w_bubble;
      r_idex_rd        <= id_rd;
      r_idex_regwrite  <= id_regwrite;
      r_idex_memread   <= id_memread;
      r_idex_rs        <= id_rs;
      r_idex_use       <= id_use;

      r_exmem_valid    <= r_idex_valid;
      r_exmem_rd       <= r_idex_rd;
      r_exmem_regwrite <= r_idex_regwrite;

      r_memwb_valid    <= r_exmem_valid;
      r_memwb_rd       <= r_exmem_rd;
      r_memwb_regwrite <= r_exmem_regwrite;

      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: forwarding build (a), no-forwarding build (b), 4-bit counter build (c),
// all sharing the same stimulus.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [11:0] id_rs;
  logic [2:0]  id_use;
  logic [3:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        ex_branch_taken;

  logic        a_pc_en, a_if_id_en, a_flush, a_bubble;
  logic [5:0]  a_fwd;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_en, b_if_id_en, b_flush, b_bubble;
  logic [5:0]  b_fwd;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic        c_pc_en, c_if_id_en, c_flush, c_bubble;
  logic [5:0]  c_fwd;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_ctrl u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use(id_use),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .pc_en(a_pc_en), .if_id_en(a_if_id_en),
    .if_id_flush(a_flush), .id_ex_bubble(a_bubble), .fwd_sel(a_fwd),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.FWD_EN(0)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use(id_use),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .pc_en(b_pc_en), .if_id_en(b_if_id_en),
    .if_id_flush(b_flush), .id_ex_bubble(b_bubble), .fwd_sel(b_fwd),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_use(id_use),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .pc_en(c_pc_en), .if_id_en(c_if_id_en),
    .if_id_flush(c_flush), .id_ex_bubble(c_bubble), .fwd_sel(c_fwd),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] rs, input logic [2:0] use_b,
                       input logic [3:0] rd, input logic rw, input logic mr);
    id_valid    = v;
    id_rs       = rs;
    id_use      = use_b;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic idle;
    drive(1'b0, 12'h000, 3'b000, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    ex_branch_taken = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    ex_branch_taken = 1'b0;
    #2;
    rst = 1'b0;
    ex_branch_taken = 1'b1;
    drive(1'b1, 12'h005, 3'b001, 4'd6, 1'b1, 1'b0);
    #1;
    checks++; if (a_pc_en !== 1'b1) begin errors++; $display("FAIL reset_pc_en: got %0b expected 1", a_pc_en); end
    checks++; if (a_if_id_en !== 1'b1) begin errors++; $display("FAIL reset_if_id_en: got %0b expected 1", a_if_id_en); end
    checks++; if (a_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b expected 0", a_flush); end
    checks++; if (a_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %0b expected 0", a_bubble); end
    checks++; if (a_fwd !== 6'd0) begin errors++; $display("FAIL reset_fwd_sel: got %0h expected 0", a_fwd); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", a_stall_cnt); end
    checks++; if (a_flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", a_flush_cnt); end
    $display("reset: pc_en=%0b flush=%0b bubble=%0b", a_pc_en, a_flush, a_bubble);
    apply_reset();
  endtask

  task automatic test_load_use;
    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd5, 1'b1, 1'b1);      // lw r5
    tick();
    drive(1'b1, 12'h005, 3'b001, 4'd6, 1'b1, 1'b0);      // consumer of r5
    #1;
    checks++; if (a_pc_en !== 1'b0) begin errors++; $display("FAIL lu_pc_en: got %0b expected 0", a_pc_en); end
    checks++; if (a_if_id_en !== 1'b0) begin errors++; $display("FAIL lu_if_id_en: got %0b expected 0", a_if_id_en); end
    checks++; if (a_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %0b expected 1", a_bubble); end
    checks++; if (a_flush !== 1'b0) begin errors++; $display("FAIL lu_flush: got %0b expected 0", a_flush); end
    tick();
    #1;
    checks++; if (a_pc_en !== 1'b1) begin errors++; $display("FAIL lu_one_cycle: got pc_en %0b expected 1", a_pc_en); end
    checks++; if (a_bubble !== 1'b0) begin errors++; $display("FAIL lu_bubble_clear: got %0b expected 0", a_bubble); end
    checks++; if (a_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", a_stall_cnt); end
    tick();
    idle();
    #1;
    checks++; if (a_fwd[1:0] !== 2'd2) begin errors++; $display("FAIL lu_fwd_memwb: got %0d expected 2", a_fwd[1:0]); end
    $display("load_use: stall_cnt=%0d fwd_sel=%0h", a_stall_cnt, a_fwd);
  endtask

  task automatic test_back_to_back;
    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd3, 1'b1, 1'b0);      // add r3
    tick();
    drive(1'b1, 12'h003, 3'b001, 4'd4, 1'b1, 1'b0);      // sub reads r3
    #1;
    checks++; if (a_pc_en !== 1'b1) begin errors++; $display("FAIL b2b_no_stall: got pc_en %0b expected 1", a_pc_en); end
    tick();
    idle();
    #1;
    checks++; if (a_fwd !== 6'b000001) begin errors++; $display("FAIL b2b_fwd_exmem: got %0h expected 01", a_fwd); end
    $display("back_to_back: fwd_sel=%0h", a_fwd);

    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd3, 1'b1, 1'b0);      // add r3
    tick();
    drive(1'b1, 12'h000, 3'b000, 4'd7, 1'b1, 1'b0);      // unrelated
    tick();
    drive(1'b1, 12'h003, 3'b001, 4'd4, 1'b1, 1'b0);      // sub reads r3
    tick();
    idle();
    #1;
    checks++; if (a_fwd !== 6'b000010) begin errors++; $display("FAIL gap1_fwd_memwb: got %0h expected 02", a_fwd); end
    $display("one_between: fwd_sel=%0h", a_fwd);

    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd3, 1'b1, 1'b0);      // add r3
    tick();
    drive(1'b1, 12'h000, 3'b000, 4'd3, 1'b1, 1'b0);      // add r3 again
    tick();
    drive(1'b1, 12'h333, 3'b101, 4'd4, 1'b1, 1'b0);      // src1 unused
    tick();
    idle();
    #1;
    checks++; if (a_fwd !== 6'b010001) begin errors++; $display("FAIL prio_use_fwd: got %0h expected 11", a_fwd); end
    $display("priority: fwd_sel=%0h", a_fwd);
  endtask

  task automatic test_branch_flush;
    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd5, 1'b1, 1'b1);      // lw r5
    tick();
    drive(1'b1, 12'h005, 3'b001, 4'd6, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    checks++; if (a_flush !== 1'b1) begin errors++; $display("FAIL br_flush: got %0b expected 1", a_flush); end
    checks++; if (a_bubble !== 1'b1) begin errors++; $display("FAIL br_bubble: got %0b expected 1", a_bubble); end
    checks++; if (a_pc_en !== 1'b1) begin errors++; $display("FAIL br_pc_en: got %0b expected 1", a_pc_en); end
    checks++; if (a_if_id_en !== 1'b1) begin errors++; $display("FAIL br_if_id_en: got %0b expected 1", a_if_id_en); end
    tick();
    ex_branch_taken = 1'b0;
    idle();
    #1;
    checks++; if (a_flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", a_flush_cnt); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 0", a_stall_cnt); end
    checks++; if (a_flush !== 1'b0) begin errors++; $display("FAIL br_flush_clear: got %0b expected 0", a_flush); end
    $display("branch: flush_cnt=%0d stall_cnt=%0d", a_flush_cnt, a_stall_cnt);
  endtask

  task automatic test_zero_reg;
    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd0, 1'b1, 1'b1);      // lw r0
    tick();
    drive(1'b1, 12'h000, 3'b001, 4'd6, 1'b1, 1'b0);      // reads r0
    #1;
    checks++; if (a_pc_en !== 1'b1) begin errors++; $display("FAIL zr_no_stall: got pc_en %0b expected 1", a_pc_en); end
    checks++; if (b_pc_en !== 1'b1) begin errors++; $display("FAIL zr_nofwd_no_stall: got pc_en %0b expected 1", b_pc_en); end
    tick();
    idle();
    #1;
    checks++; if (a_fwd !== 6'd0) begin errors++; $display("FAIL zr_fwd: got %0h expected 0", a_fwd); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL zr_stall_cnt: got %0d expected 0", a_stall_cnt); end
    $display("zero_reg: fwd_sel=%0h stall_cnt=%0d", a_fwd, a_stall_cnt);
  endtask

  task automatic test_no_forward;
    apply_reset();
    drive(1'b1, 12'h000, 3'b000, 4'd2, 1'b1, 1'b0);      // add r2
    tick();
    drive(1'b1, 12'h002, 3'b001, 4'd8, 1'b1, 1'b0);      // reads r2
    #1;
    checks++; if (b_pc_en !== 1'b0) begin errors++; $display("FAIL nf_stall1: got pc_en %0b expected 0", b_pc_en); end
    checks++; if (b_bubble !== 1'b1) begin errors++; $display("FAIL nf_bubble1: got %0b expected 1", b_bubble); end
    checks++; if (a_pc_en !== 1'b1) begin errors++; $display("FAIL fwd_alu_no_stall: got pc_en %0b expected 1", a_pc_en); end
    tick();
    #1;
    checks++; if (b_pc_en !== 1'b0) begin errors++; $display("FAIL nf_stall2: got pc_en %0b expected 0", b_pc_en); end
    checks++; if (b_fwd !== 6'd0) begin errors++; $display("FAIL nf_fwd_mid: got %0h expected 0", b_fwd); end
    tick();
    #1;
    checks++; if (b_pc_en !== 1'b1) begin errors++; $display("FAIL nf_release: got pc_en %0b expected 1", b_pc_en); end
    checks++; if (b_stall_cnt !== 16'd2) begin errors++; $display("FAIL nf_stall_cnt: got %0d expected 2", b_stall_cnt); end
    tick();
    idle();
    #1;
    checks++; if (b_fwd !== 6'd0) begin errors++; $display("FAIL nf_fwd_end: got %0h expected 0", b_fwd); end
    $display("no_forward: stall_cnt=%0d fwd_sel=%0h", b_stall_cnt, b_fwd);
  endtask

  task automatic test_saturation;
    int n_stall;
    n_stall = 0;
    apply_reset();
    drive(1'b1, 12'h005, 3'b001, 4'd5, 1'b1, 1'b1);      // lw r5,0(r5) repeated
    for (int i = 0; i < 40; i++) begin
      #1;
      if (c_pc_en === 1'b0) n_stall++;
      tick();
    end
    checks++; if (n_stall != 20) begin errors++; $display("FAIL sat_stall_cycles: got %0d expected 20", n_stall); end
    checks++; if (c_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d expected 15", c_stall_cnt); end
    checks++; if (a_stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d expected 20", a_stall_cnt); end
    $display("saturation: cnt4=%0d cnt16=%0d", c_stall_cnt, a_stall_cnt);
    tick();
    #1;
    checks++; if (c_pc_en !== 1'b0) begin errors++; $display("FAIL sat_mid_stall: got pc_en %0b expected 0", c_pc_en); end
    rst = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    checks++; if (c_pc_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pc_en: got %0b expected 1", c_pc_en); end
    checks++; if (c_if_id_en !== 1'b1) begin errors++; $display("FAIL rst_mid_if_id_en: got %0b expected 1", c_if_id_en); end
    checks++; if (c_bubble !== 1'b0) begin errors++; $display("FAIL rst_mid_bubble: got %0b expected 0", c_bubble); end
    checks++; if (c_flush !== 1'b0) begin errors++; $display("FAIL rst_mid_flush: got %0b expected 0", c_flush); end
    checks++; if (c_fwd !== 6'd0) begin errors++; $display("FAIL rst_mid_fwd: got %0h expected 0", c_fwd); end
    checks++; if (c_stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_stall_cnt: got %0d expected 0", c_stall_cnt); end
    checks++; if (c_flush_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_flush_cnt: got %0d expected 0", c_flush_cnt); end
    $display("reset_mid_stall: pc_en=%0b stall_cnt=%0d", c_pc_en, c_stall_cnt);
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_branch_flush();
    test_zero_reg();
    test_no_forward();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
